// File: rtl/ehl_tap_ntdr_if.sv
// JTAG pin and user-TDR bundle for the ehl_tap_ntdr TAP controller.
// The slave side is the TAP itself; the master side is the pin driver / TDR fabric.
interface ehl_tap_ntdr_if #(
  parameter int IR_WIDTH = 4,
  parameter int TDR_CNT  = 2
) ();
  logic                tdi;
  logic                tms;
  logic                tdo;
  logic                tdo_en;
  logic [IR_WIDTH-3:0] ir_status;
  logic [TDR_CNT-1:0]  tdr_in;
  logic [TDR_CNT-1:0]  tdr_sel;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic                run_idle;
  logic                reset_state;
  logic [IR_WIDTH-1:0] instruction;

  modport slave (
    input  tdi, tms, ir_status, tdr_in,
    output tdo, tdo_en, tdr_sel, capture_dr, shift_dr, update_dr,
           run_idle, reset_state, instruction
  );

  modport master (
    output tdi, tms, ir_status, tdr_in,
    input  tdo, tdo_en, tdr_sel, capture_dr, shift_dr, update_dr,
           run_idle, reset_state, instruction
  );
endinterface

// File: rtl/ehl_tap_ntdr.sv
// IEEE 1149.1 TAP controller with instruction decode, BYPASS/IDCODE/USERCODE
// registers and an internal TDO multiplexer over TDR_CNT user TDR chains.
module ehl_tap_ntdr #(
  parameter int          IR_WIDTH    = 4,
  parameter int          TDR_CNT     = 2,
  parameter logic [31:0] ID          = 32'h0,
  parameter bit          USERCODE_EN = 1'b0,
  parameter logic [31:0] USERCODE    = 32'h0
) (
  input logic            tck,
  input logic            trst_n,
  ehl_tap_ntdr_if.slave  tap
);

  if (IR_WIDTH < 3 || IR_WIDTH > 8) begin : g_bad_ir_width
    $error("ehl_tap_ntdr: IR_WIDTH must be in 3..8");
  end
  if (TDR_CNT < 1 || TDR_CNT > 8) begin : g_bad_tdr_cnt
    $error("ehl_tap_ntdr: TDR_CNT must be in 1..8");
  end
  if ((2 ** IR_WIDTH) - 1 <= TDR_CNT + 2) begin : g_bad_opcode_space
    $error("ehl_tap_ntdr: user TDR opcodes collide with BYPASS");
  end
  if (!ID[0] && (ID[31:1] != 31'h0)) begin : g_bad_id
    $error("ehl_tap_ntdr: ID[0]=0 requires ID[31:1]=0");
  end

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] OP_BYPASS   = '1;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(2);
  localparam bit                  ID_EN       = ID[0];
  localparam logic [IR_WIDTH-1:0] OP_RESET    = ID_EN ? OP_IDCODE : OP_BYPASS;

  tap_state_e          state;
  tap_state_e          state_nxt;
  logic [IR_WIDTH-1:0] ir_shreg;
  logic [IR_WIDTH-1:0] instr_r;
  logic                bypass_r;
  logic [31:0]         id_r;
  logic                tdo_r;
  logic                tdo_en_r;
  logic                sel_id;
  logic                sel_uc;
  logic [TDR_CNT-1:0]  sel_tdr;
  logic                dr_bit;

  // TAP state register
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TEST_LOGIC_RESET;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: state_nxt = tap.tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tap.tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_nxt = tap.tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = tap.tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_nxt = tap.tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_nxt = tap.tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_nxt = tap.tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_nxt = tap.tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_nxt = tap.tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_nxt = tap.tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = tap.tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_nxt = tap.tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_nxt = tap.tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_nxt = tap.tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_nxt = tap.tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_nxt = tap.tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

  assign tap.reset_state = (state == TEST_LOGIC_RESET);
  assign tap.run_idle    = (state == RUN_TEST_IDLE);
  assign tap.capture_dr  = (state == CAPTURE_DR);
  assign tap.shift_dr    = (state == SHIFT_DR);
  assign tap.update_dr   = (state == UPDATE_DR);

  // Instruction decode; disabled IDCODE/USERCODE and unknown opcodes fall to BYPASS
  assign sel_id = ID_EN       && (instr_r == OP_IDCODE);
  assign sel_uc = USERCODE_EN && (instr_r == OP_USERCODE);

  for (genvar k = 0; k < TDR_CNT; k++) begin : g_tdr_sel
    assign sel_tdr[k] = (instr_r == IR_WIDTH'(3 + k));
  end

  assign tap.tdr_sel     = sel_tdr;
  assign tap.instruction = instr_r;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shreg <= IR_WIDTH'(1);
    end else if (state == CAPTURE_IR) begin
      ir_shreg <= {tap.ir_status, 2'b01};
    end else if (state == SHIFT_IR) begin
      ir_shreg <= {tap.tdi, ir_shreg[IR_WIDTH-1:1]};
    end
  end

  // Instruction only commits on the falling edge inside Update-IR, so an
  // aborted IR scan never reaches the decoder.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      instr_r <= OP_RESET;
    end else if (state == TEST_LOGIC_RESET) begin
      instr_r <= OP_RESET;
    end else if (state == UPDATE_IR) begin
      instr_r <= ir_shreg;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_r <= 1'b0;
    end else if (state == CAPTURE_DR) begin
      bypass_r <= 1'b0;
    end else if (state == SHIFT_DR) begin
      bypass_r <= tap.tdi;
    end
  end

  // IDCODE and USERCODE share one 32-bit shifter
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      id_r <= ID;
    end else if (sel_id || sel_uc) begin
      if (state == CAPTURE_DR) begin
        id_r <= sel_uc ? USERCODE : ID;
      end else if (state == SHIFT_DR) begin
        id_r <= {tap.tdi, id_r[31:1]};
      end
    end
  end

  always_comb begin
    dr_bit = bypass_r;
    if (sel_id || sel_uc) dr_bit = id_r[0];
    for (int k = 0; k < TDR_CNT; k++) begin
      if (sel_tdr[k]) dr_bit = tap.tdr_in[k];
    end
  end

  // TDO launch on the falling edge; holds its last value outside Shift states
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else begin
      tdo_en_r <= (state == SHIFT_IR) || (state == SHIFT_DR);
      if (state == SHIFT_IR) begin
        tdo_r <= ir_shreg[0];
      end else if (state == SHIFT_DR) begin
        tdo_r <= dr_bit;
      end
    end
  end

  assign tap.tdo    = tdo_r;
  assign tap.tdo_en = tdo_en_r;

endmodule
